mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Sequences the single-port 512x32 main memory and shares it between two requesters: the instruction-fetch port (IF) and the load/store data port (D).
- Sits between the control unit/MAR/MDR and the memory array, and drives the memory's read/write strobes, address and write data.
- Guarantees the memory never sees read and write together and that each strobe is held for a fixed access window.

Parameters:
- ADDR_W, 9, word-address width used for range checking.
- DATA_W, 32, data width.
- DEPTH, 512, number of valid words; addresses >= DEPTH are out of range.
- ACC_CYC, 2, cycles a strobe is held per access (legal range 1..15).

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  reset, asynchronous, active-high.
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  32  fetch address (PC).
- if_gnt  out  1  one-cycle accept pulse to IF.
- if_valid  out  1  one-cycle completion pulse to IF.
- if_rdata  out  32  fetched word; held until the next IF completion.
- d_req  in  1  data request; held until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data address (MAR).
- d_wdata  in  32  store data (MDR).
- d_gnt  out  1  one-cycle accept pulse to D.
- d_valid  out  1  one-cycle completion pulse to D.
- d_rdata  out  32  loaded word; held until the next D load completion.
- err  out  1  one-cycle pulse with valid when the address was out of range.
- mem_address  out  32  registered address to memory.
- mem_data_in  out  32  registered write data to memory.
- mem_read  out  1  registered read strobe.
- mem_write  out  1  registered write strobe.
- mem_data_out  in  32  memory read data.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset: all outputs 0; state IDLE; access counter 0; owner = IF.
- States:
  - IDLE: on a clock edge with any request, pick the winner, latch its addr/we/wdata and owner, pulse that port's gnt for the next cycle, go to ACCESS.
  - ACCESS: strobe held; counter runs ACC_CYC-1 down to 0. At the edge where the counter reaches 0, go to IDLE; on a load, capture mem_data_out into the owner's rdata at that same edge.
- Completion: the owner's valid (and err, if applicable) is high for exactly the first IDLE cycle after ACCESS.
- Back-to-back requests: a new request may be accepted at the same edge that ends the valid cycle. Back-to-back throughput is one access per ACC_CYC+1 cycles.
- Latency: edge accepting the request -> valid high = ACC_CYC+1 edges.
- Priority: D beats IF when both are requesting (the in-flight instruction finishes first).
- Strobes:
  - Load: mem_read=1, mem_write=0 for all ACCESS cycles.
  - Store: mem_write=1, mem_read=0, mem_data_in=wdata for all ACCESS cycles.
  - Both strobes are 0 in IDLE. mem_address holds its last value in IDLE.
  - IF is always a read; d_we is ignored for IF.
- Out of range (addr >= DEPTH): ACCESS still spans ACC_CYC cycles but both strobes stay 0. On a load, rdata is set to 0. valid and err pulse together.
- Requester rules:
  - A requester drops req in its gnt cycle; the arbiter does not sample req outside IDLE.
  - If req stays high after gnt, it is a new request.
  - Address and data are sampled only at the accepting edge.
- clear mid-ACCESS: immediate return to IDLE, strobes drop asynchronously, no valid/gnt for the aborted access, and rdata registers are zeroed.
- gnt and valid are never high on both ports in the same cycle.

Optional Feature:
- Macro: MEM_ARB_FAIR_EN.
- Defined: when both ports request in IDLE, the winner is the port that did not own the previous access (round-robin via the owner bit). With a single requester, that requester wins.
- Undefined: fixed D-over-IF priority as above, and the owner bit is not used for arbitration.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding (IDLE, ACCESS);
  - port ID constants (PORT_IF=0, PORT_D=1);
  - ADDR_W/DATA_W/DEPTH defaults;
  - the ACC_CYC counter width (4).
- One natural sub-module: mem_arb_pick, the combinational winner select from (if_req, d_req, last owner, fairness mode). Everything else stays in the top.

Test Plan:
- Memory preloaded with word 0x47 = 0x94. D load from 0x47 with ACC_CYC=2 -> d_gnt one cycle after the accepting edge; mem_read held 2 cycles; d_valid on edge 3; d_rdata=0x94; err=0.
- D store 9 to 0x8E, then D load from 0x8E -> mem_write held 2 cycles with mem_data_in=9; load returns 9; mem_read and mem_write are never high together.
- if_req and d_req asserted in the same cycle, macro undefined -> D granted first, IF second; if_rdata equals word 0. With MEM_ARB_FAIR_EN and previous owner D -> IF granted first.
- D load from address 0x200 -> both strobes 0 throughout; d_valid and err pulse together; d_rdata=0.
- clear asserted in the second ACCESS cycle of an IF fetch -> strobes drop with no clock edge; no if_valid; busy=0; the next request is accepted normally.
- d_req held high continuously for 3 loads -> 3 d_gnt pulses spaced ACC_CYC+1 cycles apart; busy drops only after the third d_valid.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the main-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } arb_state_e;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 512;
  localparam int CNT_W      = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between the fetch and data requesters.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic if_req_i,
  input  logic d_req_i,
  input  logic owner_i,
  input  logic fair_en_i,
  output logic pick_valid_o,
  output logic pick_port_o
);

  // Contention goes to D, or to the port that did not own the last access when fair.
  always_comb begin
    pick_valid_o = if_req_i | d_req_i;
    pick_port_o  = PORT_IF;
    if (if_req_i && d_req_i) begin
      if (fair_en_i) begin
        pick_port_o = ~owner_i;
      end else begin
        pick_port_o = PORT_D;
      end
    end else if (d_req_i) begin
      pick_port_o = PORT_D;
    end else begin
      pick_port_o = PORT_IF;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Sequences the single-port main memory between fetch (IF) and load/store (D).
// Define MEM_ARB_FAIR_EN for round-robin arbitration under contention.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int ACC_CYC = 2
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              err,
  output logic [31:0]       mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy
);

`ifdef MEM_ARB_FAIR_EN
  localparam logic FAIR_EN = 1'b1;
`else
  localparam logic FAIR_EN = 1'b0;
`endif

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic              oor_q, oor_d;
  logic [31:0]       addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rd_q, rd_d, wr_q, wr_d;
  logic              if_gnt_q, if_gnt_d, d_gnt_q, d_gnt_d;
  logic              if_valid_q, if_valid_d, d_valid_q, d_valid_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic              pick_valid, pick_port;
  logic [31:0]       sel_addr;
  logic              sel_we, sel_oor;

  function automatic logic addr_oor(input logic [31:0] a);
    return (a >= 32'(DEPTH)) || ((a >> ADDR_W) != 32'd0);
  endfunction

  mem_arb_pick u_pick (
    .if_req_i    (if_req),
    .d_req_i     (d_req),
    .owner_i     (owner_q),
    .fair_en_i   (FAIR_EN),
    .pick_valid_o(pick_valid),
    .pick_port_o (pick_port)
  );

  // Next-state: accept in IDLE, count down the access window, complete on exit.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    we_d       = we_q;
    oor_d      = oor_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = 1'b0;
    wr_d       = 1'b0;
    if_gnt_d   = 1'b0;
    d_gnt_d    = 1'b0;
    if_valid_d = 1'b0;
    d_valid_d  = 1'b0;
    err_d      = 1'b0;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    sel_addr   = if_addr;
    sel_we     = 1'b0;
    sel_oor    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          sel_addr = (pick_port == PORT_D) ? d_addr : if_addr;
          sel_we   = (pick_port == PORT_D) && d_we;
          sel_oor  = addr_oor(sel_addr);
          state_d  = ACCESS;
          cnt_d    = CNT_W'(ACC_CYC - 1);
          owner_d  = pick_port;
          we_d     = sel_we;
          oor_d    = sel_oor;
          addr_d   = sel_addr;
          if (sel_we) begin
            wdata_d = d_wdata;
          end else begin
            wdata_d = wdata_q;
          end
          rd_d     = !sel_oor && !sel_we;
          wr_d     = !sel_oor && sel_we;
          if_gnt_d = (pick_port == PORT_IF);
          d_gnt_d  = (pick_port == PORT_D);
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (cnt_q == CNT_W'(0)) begin
          state_d = IDLE;
          err_d   = oor_q;
          // Out-of-range reads return zero rather than whatever the bus carries.
          if (owner_q == PORT_D) begin
            d_valid_d = 1'b1;
            if (!we_q) begin
              d_rdata_d = oor_q ? {DATA_W{1'b0}} : mem_data_out;
            end else begin
              d_rdata_d = d_rdata_q;
            end
          end else begin
            if_valid_d = 1'b1;
            if_rdata_d = oor_q ? {DATA_W{1'b0}} : mem_data_out;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          rd_d  = rd_q;
          wr_d  = wr_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; clear aborts any access and drops strobes at once.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q    <= IDLE;
      cnt_q      <= CNT_W'(0);
      owner_q    <= PORT_IF;
      we_q       <= 1'b0;
      oor_q      <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= {DATA_W{1'b0}};
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      if_gnt_q   <= 1'b0;
      d_gnt_q    <= 1'b0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      err_q      <= 1'b0;
      if_rdata_q <= {DATA_W{1'b0}};
      d_rdata_q  <= {DATA_W{1'b0}};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      oor_q      <= oor_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      if_gnt_q   <= if_gnt_d;
      d_gnt_q    <= d_gnt_d;
      if_valid_q <= if_valid_d;
      d_valid_q  <= d_valid_d;
      err_q      <= err_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign if_gnt      = if_gnt_q;
  assign d_gnt       = d_gnt_q;
  assign if_valid    = if_valid_q;
  assign d_valid     = d_valid_q;
  assign err         = err_q;
  assign if_rdata    = if_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign mem_address = addr_q;
  assign mem_data_in = wdata_q;
  assign mem_read    = rd_q;
  assign mem_write   = wr_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural 512x32 memory.
module tb_mem_port_arbiter;

  localparam int ACC   = 2;
  localparam int DEPTH = 512;

  logic        clock = 1'b0;
  logic        clear;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic        if_gnt, if_valid, d_gnt, d_valid, err, mem_read, mem_write, busy;
  logic [31:0] if_rdata, d_rdata, mem_address, mem_data_in, mem_data_out;

  logic [31:0] tb_mem  [0:DEPTH-1];
  logic [31:0] ref_mem [0:DEPTH-1];
  logic        preload;

  typedef struct {
    logic        port;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] hold_d   = 32'd0;
  logic [31:0] exp_wdata = 32'd0;
  int          run_len  = 0;
  int          last_run = 0;

  always #5 clock = ~clock;

  mem_port_arbiter dut (
    .clock       (clock),
    .clear       (clear),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_gnt      (if_gnt),
    .if_valid    (if_valid),
    .if_rdata    (if_rdata),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_gnt       (d_gnt),
    .d_valid     (d_valid),
    .d_rdata     (d_rdata),
    .err         (err),
    .mem_address (mem_address),
    .mem_data_in (mem_data_in),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_data_out(mem_data_out),
    .busy        (busy)
  );

  function automatic logic [31:0] init_word(input int a);
    if (a == 32'h47) return 32'h94;
    else return 32'h5A00_0000 | 32'(a);
  endfunction

  assign mem_data_out = tb_mem[mem_address[8:0]];

  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) tb_mem[i] <= init_word(i);
    end else if (mem_write) begin
      tb_mem[mem_address[8:0]] <= mem_data_in;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic exp_load(input logic port, input logic [31:0] addr);
    exp_t e;
    e.port  = port;
    e.err   = (addr >= 32'(DEPTH));
    e.rdata = e.err ? 32'd0 : ref_mem[addr[8:0]];
    if (port) hold_d = e.rdata;
    sb_q.push_back(e);
  endtask

  task automatic exp_store(input logic [31:0] addr, input logic [31:0] wd);
    exp_t e;
    e.port  = 1'b1;
    e.err   = (addr >= 32'(DEPTH));
    e.rdata = hold_d;
    if (!e.err) ref_mem[addr[8:0]] = wd;
    exp_wdata = wd;
    sb_q.push_back(e);
  endtask

  // Raise a request, wait (bounded) for its grant, then drop it in the grant cycle.
  task automatic issue(input logic port, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd);
    int k;
    if (port) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    for (k = 0; k < 50; k++) begin
      @(negedge clock);
      if (port ? d_gnt : if_gnt) break;
    end
    check(port ? "d_gnt_wait" : "if_gnt_wait", (k < 50) ? 32'd1 : 32'd0, 32'd1);
    if (port) begin
      d_req = 1'b0; d_addr = 32'hFFFF_FFFF; d_wdata = 32'hDEAD_DEAD;
    end else begin
      if_req = 1'b0; if_addr = 32'hFFFF_FFFF;
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 100 && sb_q.size() != 0; k++) @(negedge clock);
    check("drain", 32'(sb_q.size()), 32'd0);
    @(negedge clock);
  endtask

  // Monitor: protocol invariants each cycle, scoreboard pop on every completion.
  always @(negedge clock) begin
    if (!clear && !preload) begin
      check("rw_excl", 32'(mem_read & mem_write), 32'd0);
      check("gnt_excl", 32'(if_gnt & d_gnt), 32'd0);
      check("valid_excl", 32'(if_valid & d_valid), 32'd0);
      if (mem_write) check("wdata", mem_data_in, exp_wdata);
      if (mem_read || mem_write) begin
        check("strobe_range", (mem_address < 32'(DEPTH)) ? 32'd1 : 32'd0, 32'd1);
        run_len++;
      end else if (run_len != 0) begin
        last_run = run_len;
        run_len  = 0;
      end
      if (if_valid || d_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_valid", 32'(sb_q.size()), 32'd1);
        end else begin
          mon_e = sb_q.pop_front();
          check("valid_port", 32'(d_valid), 32'(mon_e.port));
          check("rdata", d_valid ? d_rdata : if_rdata, mon_e.rdata);
          check("err", 32'(err), 32'(mon_e.err));
          check("strobe_len", 32'(last_run), mon_e.err ? 32'd0 : 32'(ACC));
          last_run = 0;
        end
      end else begin
        check("err_alone", 32'(err), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gt[3];
    int ng, cyc, k;
    clear = 1'b1; preload = 1'b1;
    if_req = 1'b0; if_addr = 32'd0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    repeat (3) @(negedge clock);
    check("rst_ctrl", {24'd0, if_gnt, d_gnt, if_valid, d_valid, err, mem_read, mem_write, busy}, 32'd0);
    check("rst_addr", mem_address, 32'd0);
    check("rst_wdata", mem_data_in, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    clear = 1'b0; preload = 1'b0;
    @(negedge clock);

    // D load from 0x47, cycle-exact.
    exp_load(1'b1, 32'h47);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h47;
    @(negedge clock);
    check("ld_gnt", 32'(d_gnt), 32'd1);
    check("ld_rd", 32'(mem_read), 32'd1);
    check("ld_addr", mem_address, 32'h47);
    check("ld_busy", 32'(busy), 32'd1);
    d_req = 1'b0; d_addr = 32'hFFFF_FFFF;
    for (int c = 1; c < ACC; c++) begin
      @(negedge clock);
      check("ld_rd_hold", 32'(mem_read), 32'd1);
      check("ld_gnt_once", 32'(d_gnt), 32'd0);
      check("ld_no_valid", 32'(d_valid), 32'd0);
    end
    @(negedge clock);
    check("ld_valid", 32'(d_valid), 32'd1);
    check("ld_rd_off", 32'(mem_read), 32'd0);
    check("ld_rdata", d_rdata, 32'h94);
    check("ld_err", 32'(err), 32'd0);
    check("ld_busy_off", 32'(busy), 32'd0);
    wait_idle();

    // Store then reload.
    exp_store(32'h8E, 32'd9);
    issue(1'b1, 1'b1, 32'h8E, 32'd9);
    check("st_wr", 32'(mem_write), 32'd1);
    wait_idle();
    exp_load(1'b1, 32'h8E);
    issue(1'b1, 1'b0, 32'h8E, 32'd0);
    wait_idle();

    // Simultaneous requests; previous owner is D.
`ifdef MEM_ARB_FAIR_EN
    exp_load(1'b0, 32'h0);
    exp_load(1'b1, 32'h10);
`else
    exp_load(1'b1, 32'h10);
    exp_load(1'b0, 32'h0);
`endif
    fork
      issue(1'b1, 1'b0, 32'h10, 32'd0);
      issue(1'b0, 1'b0, 32'h0, 32'd0);
    join
    wait_idle();

    // Out-of-range load.
    exp_load(1'b1, 32'h200);
    issue(1'b1, 1'b0, 32'h200, 32'd0);
    check("oor_nostrobe0", 32'(mem_read | mem_write), 32'd0);
    @(negedge clock);
    check("oor_nostrobe1", 32'(mem_read | mem_write), 32'd0);
    wait_idle();

    // Clear in the second ACCESS cycle of a fetch.
    issue(1'b0, 1'b0, 32'h5, 32'd0);
    @(posedge clock);
    #2;
    check("ab_rd_before", 32'(mem_read), 32'd1);
    clear = 1'b1;
    #1;
    check("ab_rd_drop", 32'(mem_read), 32'd0);
    check("ab_busy", 32'(busy), 32'd0);
    check("ab_d_rdata", d_rdata, 32'd0);
    #1;
    clear = 1'b0;
    hold_d = 32'd0;
    repeat (4) @(negedge clock);
    check("ab_no_valid", 32'(if_valid), 32'd0);
    exp_load(1'b0, 32'h0);
    issue(1'b0, 1'b0, 32'h0, 32'd0);
    wait_idle();

    // d_req held across three loads.
    exp_load(1'b1, 32'h20);
    exp_load(1'b1, 32'h21);
    exp_load(1'b1, 32'h22);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    ng = 0; cyc = 0;
    for (int c = 0; c < 60 && ng < 3; c++) begin
      @(negedge clock);
      cyc++;
      if (d_gnt) begin
        gt[ng] = cyc;
        ng++;
        d_addr = 32'h20 + 32'(ng);
        if (ng == 3) d_req = 1'b0;
      end
    end
    check("hold_gnts", 32'(ng), 32'd3);
    if (ng == 3) begin
      check("hold_space1", 32'(gt[1] - gt[0]), 32'(ACC + 1));
      check("hold_space2", 32'(gt[2] - gt[1]), 32'(ACC + 1));
    end
    for (k = 0; k < 20 && !d_valid; k++) begin
      check("hold_busy", 32'(busy), 32'd1);
      @(negedge clock);
    end
    check("hold_last_valid", 32'(d_valid), 32'd1);
    @(negedge clock);
    check("hold_busy_off", 32'(busy), 32'd0);
    wait_idle();

    check("final_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
